// File: rtl/tone_direction_detect_pkg.sv
// Shared definitions for the tone direction detector: direction codes,
// classification band bounds, FSM state encodings and the band classifier.
package tone_direction_detect_pkg;

    // Detector FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LATCHED = 2'd2
    } toneState_t;

    // Direction codes seen by Drive; TD_HOLD doubles as "no class"
    localparam logic [2:0] TD_HOLD    = 3'd0;
    localparam logic [2:0] TD_FORWARD = 3'd1;
    localparam logic [2:0] TD_LEFT    = 3'd2;
    localparam logic [2:0] TD_RIGHT   = 3'd3;
    localparam logic [2:0] TD_REVERSE = 3'd4;
    localparam logic [2:0] TD_STOP    = 3'd5;

    // Inclusive edge-count bands per window
    localparam logic [5:0] FWD_LO  = 6'd8;
    localparam logic [5:0] FWD_HI  = 6'd12;
    localparam logic [5:0] LEFT_LO = 6'd18;
    localparam logic [5:0] LEFT_HI = 6'd22;
    localparam logic [5:0] RGT_LO  = 6'd28;
    localparam logic [5:0] RGT_HI  = 6'd32;
    localparam logic [5:0] REV_LO  = 6'd38;
    localparam logic [5:0] REV_HI  = 6'd42;
    localparam logic [5:0] STOP_LO = 6'd48;
    localparam logic [5:0] STOP_HI = 6'd52;

    // Edge counter saturation value
    localparam logic [5:0] EDGE_MAX = 6'd63;

    // Map a window edge count onto a direction code (TD_HOLD when out of band)
    function automatic logic [2:0] classifyCount(input logic [5:0] count);
        logic [2:0] cls;
        cls = TD_HOLD;
        if (count >= FWD_LO && count <= FWD_HI) begin
            cls = TD_FORWARD;
        end else if (count >= LEFT_LO && count <= LEFT_HI) begin
            cls = TD_LEFT;
        end else if (count >= RGT_LO && count <= RGT_HI) begin
            cls = TD_RIGHT;
        end else if (count >= REV_LO && count <= REV_HI) begin
            cls = TD_REVERSE;
        end else if (count >= STOP_LO && count <= STOP_HI) begin
            cls = TD_STOP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// Brings the asynchronous comparator tone into the clk domain through a
// two-flop synchronizer and emits a registered one-cycle pulse per rising
// edge, three cycles after the input edge.
module tone_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic toneIn,
    output logic edgePulse
);

    logic syncMeta;
    logic syncStable;
    logic syncPrev;

    // Synchronizer chain, edge history and registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta   <= 1'b0;
            syncStable <= 1'b0;
            syncPrev   <= 1'b0;
            edgePulse  <= 1'b0;
        end else begin
            syncMeta   <= toneIn;
            syncStable <= syncMeta;
            syncPrev   <= syncStable;
            edgePulse  <= syncStable & ~syncPrev;
        end
    end

endmodule

// File: rtl/tone_direction_detect.sv
// Tone direction detector: counts tone edges per fixed window, classifies
// the count into a direction band and latches the direction for Drive.
// Optional macro TONE_CONFIRM_EN: require CONFIRM_WINDOWS consecutive
// matching windows before latching; without it the first in-band window
// latches directly.
module tone_direction_detect
    import tone_direction_detect_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 500000,
    parameter int CONFIRM_WINDOWS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       toneIn,
    input  logic       enableToneDetection,
    output logic [2:0] toneDir,
    output logic       toneValid,
    output logic [5:0] toneCount
);

    localparam int WinWidth = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WinWidth-1:0] WinLast = WinWidth'(WINDOW_CYCLES - 1);

    toneState_t          state;
    toneState_t          nextState;
    logic                edgePulse;
    logic [WinWidth-1:0] winCnt;
    logic [5:0]          edgeCnt;
    logic [5:0]          endCount;
    logic                windowEnd;
    logic                classifyPending;
    logic                latchReq;
    logic [2:0]          latchClass;
    logic [2:0]          winClass;
    logic                latchHit;

    tone_sync_edge uSyncEdge (
        .clk       (clk),
        .rst       (rst),
        .toneIn    (toneIn),
        .edgePulse (edgePulse)
    );

    assign windowEnd = (state == ST_MEASURE) && (winCnt == WinLast);
    assign winClass  = classifyCount(toneCount);
    assign toneValid = (toneDir != TD_HOLD);

    // Edge count including this cycle's pulse, saturating at EDGE_MAX
    always_comb begin
        endCount = edgeCnt;
        if (edgePulse && (edgeCnt != EDGE_MAX)) begin
            endCount = edgeCnt + 6'd1;
        end
    end

`ifdef TONE_CONFIRM_EN
    localparam int MatchWidth = (CONFIRM_WINDOWS > 1) ? $clog2(CONFIRM_WINDOWS + 1) : 1;
    localparam logic [MatchWidth-1:0] MatchTarget = MatchWidth'(CONFIRM_WINDOWS);

    logic [MatchWidth-1:0] matchCnt;
    logic [MatchWidth-1:0] matchNext;
    logic [2:0]            prevClass;

    // Run length of identical in-band classes, reset by an out-of-band window
    always_comb begin
        matchNext = '0;
        if (winClass == TD_HOLD) begin
            matchNext = '0;
        end else if (winClass == prevClass) begin
            matchNext = (matchCnt == MatchTarget) ? matchCnt : matchCnt + MatchWidth'(1);
        end else begin
            matchNext = MatchWidth'(1);
        end
    end

    assign latchHit = (matchNext == MatchTarget);

    // Match history, updated once per classified window and cleared outside MEASURE
    always_ff @(posedge clk) begin
        if (rst || !enableToneDetection || (state != ST_MEASURE)) begin
            matchCnt  <= '0;
            prevClass <= TD_HOLD;
        end else if (classifyPending) begin
            matchCnt  <= matchNext;
            prevClass <= winClass;
        end
    end
`else
    // CONFIRM_WINDOWS has no effect in this build; any in-band window latches
    assign latchHit = (winClass != TD_HOLD) && (CONFIRM_WINDOWS >= 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; dropping the enable always returns to IDLE
    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE:    if (enableToneDetection) nextState = ST_MEASURE;
            ST_MEASURE: if (latchReq) nextState = ST_LATCHED;
            ST_LATCHED: nextState = ST_LATCHED;
            default:    nextState = ST_IDLE;
        endcase
        if (!enableToneDetection) begin
            nextState = ST_IDLE;
        end
    end

    // Window timing, edge counting, classification pipeline and output latch
    always_ff @(posedge clk) begin
        if (rst || !enableToneDetection) begin
            winCnt          <= '0;
            edgeCnt         <= '0;
            toneCount       <= '0;
            classifyPending <= 1'b0;
            latchReq        <= 1'b0;
            latchClass      <= TD_HOLD;
            toneDir         <= TD_HOLD;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    winCnt          <= '0;
                    edgeCnt         <= '0;
                    classifyPending <= 1'b0;
                    latchReq        <= 1'b0;
                    toneDir         <= TD_HOLD;
                end
                ST_MEASURE: begin
                    if (latchReq) begin
                        toneDir         <= latchClass;
                        latchReq        <= 1'b0;
                        winCnt          <= '0;
                        edgeCnt         <= '0;
                        classifyPending <= 1'b0;
                    end else begin
                        if (windowEnd) begin
                            winCnt          <= '0;
                            edgeCnt         <= '0;
                            toneCount       <= endCount;
                            classifyPending <= 1'b1;
                        end else begin
                            winCnt          <= winCnt + WinWidth'(1);
                            edgeCnt         <= endCount;
                            classifyPending <= 1'b0;
                        end
                        if (classifyPending) begin
                            latchReq   <= latchHit;
                            latchClass <= winClass;
                        end
                    end
                end
                ST_LATCHED: begin
                    winCnt          <= '0;
                    edgeCnt         <= '0;
                    classifyPending <= 1'b0;
                    latchReq        <= 1'b0;
                end
                default: begin
                    toneDir <= TD_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_direction_detect.sv
// Directed testbench for tone_direction_detect with a short window.
// Expectations follow the TONE_CONFIRM_EN setting of the build.
module tb_tone_direction_detect;

    localparam int W = 600;
    localparam int CONFIRM = 3;
`ifdef TONE_CONFIRM_EN
    localparam int LATCH_WINS = 3;
`else
    localparam int LATCH_WINS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       toneIn = 1'b0;
    logic       enableToneDetection = 1'b0;
    logic [2:0] toneDir;
    logic       toneValid;
    logic [5:0] toneCount;

    int compared = 0;
    int mismatched = 0;

    bit toneOn = 1'b0;
    bit manualTone = 1'b0;
    int tonePeriod = 60;
    int toneStart = 0;
    int cycleCount = 0;

    tone_direction_detect #(
        .WINDOW_CYCLES   (W),
        .CONFIRM_WINDOWS (CONFIRM)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .toneIn              (toneIn),
        .enableToneDetection (enableToneDetection),
        .toneDir             (toneDir),
        .toneValid           (toneValid),
        .toneCount           (toneCount)
    );

    always #5 clk = ~clk;

    // Tone source: periodic square wave or a manual level, updated 1 ns after each posedge
    always @(posedge clk) begin
        #1;
        cycleCount = cycleCount + 1;
        if (toneOn)
            toneIn = (((cycleCount - toneStart) % tonePeriod) < (tonePeriod / 2));
        else
            toneIn = manualTone;
    end

    task automatic startTone(input int period);
        tonePeriod = period;
        toneStart  = cycleCount;
        toneOn     = 1'b1;
    endtask

    task automatic stopAll();
        enableToneDetection = 1'b0;
        toneOn = 1'b0;
        manualTone = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        startTone(60);
        enableToneDetection = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_dir actual=%0d expected=0", toneDir); end
        compared++;
        if (toneValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid actual=%0b expected=0", toneValid); end
        compared++;
        if (toneCount !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_count actual=%0d expected=0", toneCount); end
        rst = 1'b0;
        stopAll();
    endtask

    // 10 edges per window -> FORWARD
    task automatic test_forward();
        int waited;
        startTone(60);
        repeat (130) @(negedge clk);
        enableToneDetection = 1'b1;
        repeat (LATCH_WINS * W) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL fwd_hold actual=%0d expected=0", toneDir); end
        waited = 0;
        while (toneValid !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        compared++;
        if (toneValid !== 1'b1) begin mismatched++; $display("[TB] FAIL fwd_valid actual=%0b expected=1", toneValid); end
        compared++;
        if (toneDir !== 3'd1) begin mismatched++; $display("[TB] FAIL fwd_dir actual=%0d expected=1", toneDir); end
        compared++;
        if (toneCount !== 6'd10) begin mismatched++; $display("[TB] FAIL fwd_count actual=%0d expected=10", toneCount); end
        stopAll();
    endtask

    // 30 edges per window for two windows, then 20 per window
    task automatic test_switch();
        int waited;
        startTone(20);
        repeat (130) @(negedge clk);
        enableToneDetection = 1'b1;
`ifdef TONE_CONFIRM_EN
        repeat (2 * W) @(negedge clk);
        startTone(30);
        repeat (5) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL switch_hold2 actual=%0d expected=0", toneDir); end
        repeat (3 * W - 5) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL switch_hold5 actual=%0d expected=0", toneDir); end
        waited = 0;
        while (toneValid !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        compared++;
        if (toneDir !== 3'd2) begin mismatched++; $display("[TB] FAIL switch_dir actual=%0d expected=2", toneDir); end
`else
        repeat (W) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL switch_hold1 actual=%0d expected=0", toneDir); end
        waited = 0;
        while (toneValid !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        compared++;
        if (toneDir !== 3'd3) begin mismatched++; $display("[TB] FAIL switch_dir actual=%0d expected=3", toneDir); end
`endif
        stopAll();
    endtask

    // 120 edges per window saturate at 63 and never classify
    task automatic test_saturate();
        startTone(5);
        repeat (130) @(negedge clk);
        enableToneDetection = 1'b1;
        repeat (W + 1) @(negedge clk);
        compared++;
        if (toneCount !== 6'd63) begin mismatched++; $display("[TB] FAIL sat_count actual=%0d expected=63", toneCount); end
        repeat (3 * W) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL sat_dir actual=%0d expected=0", toneDir); end
        compared++;
        if (toneValid !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_valid actual=%0b expected=0", toneValid); end
        compared++;
        if (toneCount !== 6'd63) begin mismatched++; $display("[TB] FAIL sat_count_late actual=%0d expected=63", toneCount); end
        stopAll();
    endtask

    // Latch REVERSE, hold it, drop enable for one cycle, then measure afresh
    task automatic test_enable_drop();
        int waited;
        startTone(15);
        repeat (130) @(negedge clk);
        enableToneDetection = 1'b1;
        repeat (LATCH_WINS * W) @(negedge clk);
        waited = 0;
        while (toneValid !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        compared++;
        if (toneDir !== 3'd4) begin mismatched++; $display("[TB] FAIL drop_latch actual=%0d expected=4", toneDir); end
        repeat (2 * W) @(negedge clk);
        compared++;
        if (toneDir !== 3'd4) begin mismatched++; $display("[TB] FAIL drop_held actual=%0d expected=4", toneDir); end
        enableToneDetection = 1'b0;
        @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL drop_dir actual=%0d expected=0", toneDir); end
        compared++;
        if (toneValid !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_valid actual=%0b expected=0", toneValid); end
        enableToneDetection = 1'b1;
        repeat (W) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL drop_rehold actual=%0d expected=0", toneDir); end
        @(negedge clk);
        compared++;
        if (toneCount !== 6'd40) begin mismatched++; $display("[TB] FAIL drop_recount actual=%0d expected=40", toneCount); end
        stopAll();
    endtask

    // Reset in the middle of window 2 of a STOP tone, then relatch
    task automatic test_reset_midwindow();
        int waited;
        startTone(12);
        repeat (130) @(negedge clk);
        enableToneDetection = 1'b1;
        repeat (W + W / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL rstmid_dir actual=%0d expected=0", toneDir); end
        compared++;
        if (toneValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_valid actual=%0b expected=0", toneValid); end
        compared++;
        if (toneCount !== 6'd0) begin mismatched++; $display("[TB] FAIL rstmid_count actual=%0d expected=0", toneCount); end
        rst = 1'b0;
        repeat (LATCH_WINS * W) @(negedge clk);
        compared++;
        if (toneDir !== 3'd0) begin mismatched++; $display("[TB] FAIL rstmid_hold actual=%0d expected=0", toneDir); end
        waited = 0;
        while (toneValid !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        compared++;
        if (toneDir !== 3'd5) begin mismatched++; $display("[TB] FAIL rstmid_relatch actual=%0d expected=5", toneDir); end
        stopAll();
    endtask

    // Single-cycle tone pulses placed so one edge pulse lands on the last window cycle
    task automatic test_boundary();
        bit rise;
        enableToneDetection = 1'b1;
        for (int m = 0; m <= 2 * W + 1; m++) begin
            if (m == W + 1) begin
                compared++;
                if (toneCount !== 6'd10) begin mismatched++; $display("[TB] FAIL bound_w1 actual=%0d expected=10", toneCount); end
            end
`ifdef TONE_CONFIRM_EN
            if (m == 2 * W + 1) begin
                compared++;
                if (toneCount !== 6'd6) begin mismatched++; $display("[TB] FAIL bound_w2 actual=%0d expected=6", toneCount); end
            end
`else
            if (m == W + 3) begin
                compared++;
                if (toneDir !== 3'd1) begin mismatched++; $display("[TB] FAIL bound_dir actual=%0d expected=1", toneDir); end
            end
`endif
            rise = ((m >= 10) && (m <= 90) && (m % 10 == 0)) ||
                   (m == W - 4) || (m == W - 2) ||
                   ((m > W) && (m <= W + 40) && ((m - W) % 10 == 0)) ||
                   (m == 2 * W - 4);
            manualTone = rise;
            @(negedge clk);
        end
        stopAll();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_forward();
        test_switch();
        test_saturate();
        test_enable_drop();
        test_reset_midwindow();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
